// File: rtl/fc_host_port.sv
// Host-side driver for one FC layer: buffers an input vector, streams it out, collects results.
// Optional build macro FC_HOST_CHECK_EN adds a sticky stream-protocol error flag on err.
module fc_host_port #(
  parameter int M = 8,
  parameter int N = 4,
  parameter int T = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [$clog2(N)-1:0]  wr_addr,
  input  logic signed [T-1:0]   wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [$clog2(M)-1:0]  rd_addr,
  output logic signed [T-1:0]   rd_data,
  output logic                  fc_input_valid,
  input  logic                  fc_input_ready,
  output logic signed [T-1:0]   fc_input_data,
  input  logic                  fc_output_valid,
  output logic                  fc_output_ready,
  input  logic signed [T-1:0]   fc_output_data,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  // Both stream ports use valid/ready: a beat moves on a rising edge where valid and
  // ready are both high; the sender holds valid and data stable until that edge.

  localparam int NAW = $clog2(N);
  localparam int MAW = $clog2(M);
  localparam int SW  = $clog2(N + 1);
  localparam int RW  = $clog2(M + 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t              state;
  logic [SW-1:0]       send_cnt;
  logic [RW-1:0]       recv_cnt;
  logic signed [T-1:0] xbuf [N];
  logic signed [T-1:0] rbuf [M];

  logic [SW-1:0]       send_nxt;
  logic                in_fire;
  logic                out_fire;
  logic                x_wr;
  logic signed [T-1:0] x0_fwd;

  assign state_dbg = state;
  assign send_nxt  = send_cnt + SW'(1);
  assign in_fire   = (state == SEND) && fc_input_valid && fc_input_ready;
  assign out_fire  = (state == RECV) && fc_output_valid && fc_output_ready;
  assign x_wr      = wr_en && (state == IDLE);
  // A write to element 0 in the start cycle must be the first element sent.
  assign x0_fwd    = (x_wr && wr_addr == '0) ? wr_data : xbuf[0];

  // Buffers have no reset so results survive a mid-transaction reset.
  always_ff @(posedge clk) begin
    if (!reset && x_wr)
      xbuf[wr_addr] <= wr_data;
    if (!reset && out_fire)
      rbuf[recv_cnt[MAW-1:0]] <= fc_output_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      send_cnt        <= '0;
      recv_cnt        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      fc_input_valid  <= 1'b0;
      fc_output_ready <= 1'b0;
      fc_input_data   <= '0;
      rd_data         <= '0;
    end else begin
      rd_data <= rbuf[rd_addr];
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= SEND;
            send_cnt       <= '0;
            recv_cnt       <= '0;
            busy           <= 1'b1;
            fc_input_valid <= 1'b1;
            fc_input_data  <= x0_fwd;
          end
        end
        SEND: begin
          if (in_fire) begin
            send_cnt <= send_nxt;
            if (send_cnt == SW'(N - 1)) begin
              state           <= RECV;
              fc_input_valid  <= 1'b0;
              fc_output_ready <= 1'b1;
            end else begin
              fc_input_data <= xbuf[send_nxt[NAW-1:0]];
            end
          end
        end
        RECV: begin
          if (out_fire) begin
            recv_cnt <= recv_cnt + RW'(1);
            if (recv_cnt == RW'(M - 1)) begin
              state           <= DONE;
              fc_output_ready <= 1'b0;
              done            <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FC_HOST_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if ((fc_output_valid && state != RECV) ||
             (state == SEND && fc_input_ready && !fc_input_valid))
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fc_host_port.sv
// Directed and randomized bench for fc_host_port against a vector/result array model.
module tb_fc_host_port;
  localparam int M = 8;
  localparam int N = 4;
  localparam int T = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 wr_en;
  logic [$clog2(N)-1:0] wr_addr;
  logic [T-1:0]         wr_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [$clog2(M)-1:0] rd_addr;
  logic [T-1:0]         rd_data;
  logic                 fc_input_valid;
  logic                 fc_input_ready;
  logic [T-1:0]         fc_input_data;
  logic                 fc_output_valid;
  logic                 fc_output_ready;
  logic [T-1:0]         fc_output_data;
  logic                 err;
  logic [1:0]           state_dbg;

  fc_host_port #(.M(M), .N(N), .T(T)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .fc_input_valid(fc_input_valid), .fc_input_ready(fc_input_ready),
    .fc_input_data(fc_input_data), .fc_output_valid(fc_output_valid),
    .fc_output_ready(fc_output_ready), .fc_output_data(fc_output_data),
    .err(err), .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // model and scoreboard
  logic [T-1:0] xm [N];
  logic [T-1:0] rm [M];
  logic [T-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=completion", tag);
  endtask

  // drivers
  task automatic host_write(input int a, input logic [T-1:0] d);
    wr_en = 1'b1; wr_addr = a[$clog2(N)-1:0]; wr_data = d;
    xm[a] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic start_txn(input bit with_write, input int wa, input logic [T-1:0] wd);
    start = 1'b1;
    if (with_write) begin
      wr_en = 1'b1; wr_addr = wa[$clog2(N)-1:0]; wr_data = wd;
      xm[wa] = wd;
    end
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(xm[i]);
    step();
    start = 1'b0; wr_en = 1'b0;
    check("start_valid", fc_input_valid, 1);
    check("start_busy", busy, 1);
  endtask

  // mode 0: ready low on cycles set in low_mask; mode 1: random ready
  task automatic run_send(input int mode, input logic [31:0] low_mask);
    int c = 0;
    int sent = 0;
    logic r;
    while (sent < N && c < 200) begin
      r = (mode == 1) ? 1'($urandom_range(0, 1)) : !low_mask[c];
      fc_input_ready = r;
      check("send_valid", fc_input_valid, 1);
      check("send_data", fc_input_data, exp_q[0]);
      if (r) begin
        void'(exp_q.pop_front());
        sent++;
      end
      step();
      c++;
    end
    fc_input_ready = 1'b0;
    if (sent < N) timeout_fail("send_timeout");
    check("send_end_valid", fc_input_valid, 0);
    check("recv_ready", fc_output_ready, 1);
  endtask

  // mode 0: results 10+i with valid on every other cycle; mode 1: random
  task automatic run_recv(input int mode, input bit poke);
    int c = 0;
    int acc = 0;
    logic v;
    while (acc < M && c < 300) begin
      v = (mode == 1) ? 1'($urandom_range(0, 1)) : (c % 2 == 0);
      if (poke && c == 1) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 16'd99;
      end
      fc_output_valid = v;
      fc_output_data  = (mode == 1) ? T'($urandom) : T'(10 + acc);
      check("recv_busy", busy, 1);
      check("recv_done_low", done, 0);
      check("recv_ready_hi", fc_output_ready, 1);
      if (v) begin
        rm[acc] = fc_output_data;
        acc++;
      end
      step();
      start = 1'b0; wr_en = 1'b0;
      c++;
    end
    fc_output_valid = 1'b0;
    if (acc < M) timeout_fail("recv_timeout");
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_ready_low", fc_output_ready, 0);
    step();
    check("done_clear", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic read_all();
    int off;
    int a;
    off = $urandom_range(0, M - 1);
    for (int i = 0; i < M; i++) begin
      a = (i * 3 + off) % M;
      rd_addr = a[$clog2(M)-1:0];
      step();
      check("rd_data", rd_data, rm[a]);
    end
  endtask

  // directed sequence
  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    rd_addr = '0; fc_input_ready = 1'b0; fc_output_valid = 1'b0; fc_output_data = '0;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_valid", fc_input_valid, 0);
    check("rst_out_ready", fc_output_ready, 0);
    check("rst_err", err, 0);
    check("rst_in_data", fc_input_data, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    step();

    // basic vector, no stalls, alternating result valid
    for (int i = 0; i < N; i++) host_write(i, T'(i + 1));
    start_txn(0, 0, '0);
    run_send(0, 32'h0);
    run_recv(0, 0);
    rd_addr = 3'd3;
    step();
    check("rd_addr3", rd_data, 13);
    read_all();

    // ready low on 2nd and 3rd SEND cycles
    start_txn(0, 0, '0);
    run_send(0, 32'b0110);
    run_recv(1, 0);

    // start and write during RECV are ignored
    start_txn(0, 0, '0);
    run_send(1, 32'h0);
    run_recv(1, 1);
    check("poke_no_restart", fc_input_valid, 0);
    start_txn(0, 0, '0);
    run_send(0, 32'h0);
    run_recv(1, 0);
    read_all();

    // reset after two transfers
    start_txn(0, 0, '0);
    fc_input_ready = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    fc_input_ready = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_valid", fc_input_valid, 0);
    check("midrst_ready", fc_output_ready, 0);
    check("midrst_done", done, 0);
    step();
    check("post_rst_idle_busy", busy, 0);
    start_txn(1, 0, 16'h8001);
    run_send(1, 32'h0);
    run_recv(1, 0);
    read_all();

    // random transactions with same-cycle write on start
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) host_write(i, T'($urandom));
      start_txn(1, $urandom_range(0, N - 1), T'($urandom));
      run_send(1, 32'h0);
      run_recv(1, 0);
      read_all();
    end

    // result valid while idle
    fc_output_valid = 1'b1;
    fc_output_data  = 16'h5555;
    step();
    fc_output_valid = 1'b0;
    check("idle_valid_busy", busy, 0);
`ifdef FC_HOST_CHECK_EN
    check("err_set", err, 1);
    step();
    check("err_held", err, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("err_cleared", err, 0);
`else
    check("err_tied", err, 0);
    step();
    check("err_tied_later", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fc_host_port.md
# fc_host_port

Host-side driver for an M-output, N-input fully connected layer core. It buffers an N-element input vector written by the host and streams it into the layer's input handshake. It then accepts the M results from the layer's output handshake and stores them in a result buffer the host reads by address. It is the opposite end of both layer stream ports and sits between the host register interface and one FC layer instance.

## Interface
Parameters:
- M, 8, number of layer outputs (result buffer depth)
- N, 4, number of layer inputs (vector buffer depth)
- T, 16, data width, two's complement

Ports:
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  host write strobe for the vector buffer
- wr_addr  in  $clog2(N)  vector element index
- wr_data  in  T  signed vector element
- start  in  1  begin one layer transaction
- busy  out  1  high in SEND, RECV and DONE
- done  out  1  one-cycle pulse when all M results are stored
- rd_addr  in  $clog2(M)  result index
- rd_data  out  T  signed result; registered, 1-cycle latency
- fc_input_valid  out  1  vector element valid to layer
- fc_input_ready  in  1  layer accepts element
- fc_input_data  out  T  vector element to layer
- fc_output_valid  in  1  layer result valid
- fc_output_ready  out  1  block accepts result
- fc_output_data  in  T  layer result
- err  out  1  sticky protocol error flag (see Configuration)

## Operation
- State machine: IDLE → SEND → RECV → DONE → IDLE.
- IDLE:
  - wr_en writes wr_data to xbuf[wr_addr].
  - start moves to SEND and clears send_cnt and recv_cnt.
- SEND:
  - fc_input_valid=1 and fc_input_data=xbuf[send_cnt].
  - A transfer occurs when valid and fc_input_ready are both high; send_cnt then increments.
  - The transfer with send_cnt==N-1 moves to RECV.
- RECV:
  - fc_output_ready=1.
  - Each cycle with fc_output_valid high writes fc_output_data to rbuf[recv_cnt] and increments recv_cnt.
  - The accept with recv_cnt==M-1 moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Counters: send_cnt is $clog2(N+1) bits and recv_cnt is $clog2(M+1) bits; neither wraps within a transaction.
- Host access:
  - rd_data <= rbuf[rd_addr] every cycle, in any state.
  - wr_en outside IDLE is ignored.
  - start outside IDLE is ignored.
- Data is passed unchanged, with no arithmetic or saturation; the full T bits are stored.

## Timing
- Reset values:
  - state=IDLE.
  - busy, done, fc_input_valid, fc_output_ready, err = 0.
  - fc_input_data=0 and rd_data=0.
  - Buffer contents are not cleared.
- start sampled at edge k: fc_input_valid=1 from cycle k+1.
- With fc_input_ready held high, elements 0..N-1 go out on cycles k+1..k+N and RECV begins at k+N+1.
- Input stall: while fc_input_ready is low, fc_input_valid and fc_input_data hold stable.
- Result timing: the last result is accepted at edge j, done=1 during cycle j+1, and busy=0 from cycle j+2.
- wr_en and start in the same IDLE cycle: the write lands, and SEND transmits the new value.
- fc_output_valid during SEND is not accepted, because fc_output_ready=0.
- Reset asserted mid-transaction:
  - Next cycle is IDLE with valid and ready low.
  - Partially filled rbuf entries keep what was written.

## Configuration
- FC_HOST_CHECK_EN defined: err is set and held until reset when either of these occurs:
  - fc_output_valid=1 in any state other than RECV;
  - fc_input_ready=1 while fc_input_valid=0 and state is SEND. This cannot occur in a correct design; it is a guard.
- FC_HOST_CHECK_EN undefined: err is tied 0 and no check logic is built.

## Test plan
- Write x={1,2,3,4}, start, fc_input_ready=1 → fc_input_data 1,2,3,4 on 4 consecutive cycles; fc_input_valid=0 on the 5th; fc_output_ready=1.
- Same vector with fc_input_ready low on the 2nd and 3rd SEND cycles → data holds at 2 for 3 cycles; exactly 4 transfers.
- In RECV, drive results 10..17 with fc_output_valid low every other cycle → done pulses once, the cycle after the 8th accept; rd_addr=3 returns 13 one cycle later.
- Pulse start and wr_en(addr 0, value 99) during RECV → no restart and no buffer change; the next transaction sends 1 first.
- Assert reset during SEND after 2 transfers → next cycle IDLE, busy=0, fc_input_valid=0; a new start sends all 4 elements.
- With FC_HOST_CHECK_EN defined, drive fc_output_valid=1 in IDLE → err=1 next cycle and held until reset. Without the macro, err stays 0.
